// File: rtl/cnn_pkg.sv
// Shared types and default widths for the CNN layer blocks.
// Pooling mode encoding and the pooling FSM state set live here.
package cnn_pkg;
  localparam int CNN_DATA_SZ = 16;
  localparam int CNN_ADDR_SZ = 16;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } pool_state_e;
endpackage

// File: rtl/pooling_layer_reduce.sv
// Combinational 2x2 window reduction: signed max or floor average.
// An optional ReLU clamp is applied to the reduced value.
module pool_reduce_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_SZ = CNN_DATA_SZ,
  parameter bit RELU    = 1'b0
) (
  input  pool_mode_e                  i_mode,
  input  logic signed [DATA_SZ-1:0]   i_w0,
  input  logic signed [DATA_SZ-1:0]   i_w1,
  input  logic signed [DATA_SZ-1:0]   i_w2,
  input  logic signed [DATA_SZ-1:0]   i_w3,
  output logic signed [DATA_SZ-1:0]   o_result
);
  logic signed [DATA_SZ-1:0] w_max01, w_max23, w_max, w_pooled;
  logic signed [DATA_SZ+1:0] w_sum, w_avg;

  always_comb begin
    w_max01 = (i_w0 > i_w1) ? i_w0 : i_w1;
    w_max23 = (i_w2 > i_w3) ? i_w2 : i_w3;
    w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
    // Two guard bits make the 4-term sum exact; >>> floors toward -inf.
    w_sum   = {{2{i_w0[DATA_SZ-1]}}, i_w0} + {{2{i_w1[DATA_SZ-1]}}, i_w1}
            + {{2{i_w2[DATA_SZ-1]}}, i_w2} + {{2{i_w3[DATA_SZ-1]}}, i_w3};
    w_avg   = w_sum >>> 2;
    w_pooled = (i_mode == POOL_MAX) ? w_max : w_avg[DATA_SZ-1:0];
    o_result = w_pooled;
    if (RELU && w_pooled < 0) o_result = '0;
  end
endmodule

// File: rtl/pooling_layer.sv
// 2x2 stride-2 pooling over C feature maps held in word-serial memory.
// Reads each window element-by-element, reduces, writes one word per window.
module pooling_layer
  import cnn_pkg::*;
#(
  parameter int DATA_SZ = CNN_DATA_SZ,
  parameter int ADDR_SZ = CNN_ADDR_SZ,
  parameter bit RELU    = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  pool_mode_e          i_mode,
  input  logic [DATA_SZ-1:0]  i_imgs_number,
  input  logic [DATA_SZ-1:0]  i_img_size,
  input  logic [ADDR_SZ-1:0]  i_in_address,
  input  logic [ADDR_SZ-1:0]  i_out_address,
  output logic                o_rd_en,
  output logic [ADDR_SZ-1:0]  o_rd_addr,
  input  logic [DATA_SZ-1:0]  i_rd_data,
  input  logic                i_rd_valid,
  output logic                o_wr_en,
  output logic [ADDR_SZ-1:0]  o_wr_addr,
  output logic [DATA_SZ-1:0]  o_wr_data,
  output logic                o_done
);
  pool_state_e              r_state, w_next;
  pool_mode_e               r_mode;
  logic [DATA_SZ-1:0]       r_c_num, r_s, r_o, r_q, r_r, r_c;
  logic [ADDR_SZ-1:0]       r_ss, r_map_base, r_row_base, r_wr_addr;
  logic [1:0]               r_k;
  logic signed [DATA_SZ-1:0] r_win [4];

  logic [ADDR_SZ-1:0]       w_s_a, w_q_a, w_rd_addr;
  logic                     w_last_q, w_last_r, w_last_c;
  logic signed [DATA_SZ-1:0] w_pooled;

  assign w_s_a     = ADDR_SZ'(r_s);
  assign w_q_a     = ADDR_SZ'(r_q);
  assign w_rd_addr = r_row_base + (r_k[1] ? w_s_a : '0) + {w_q_a[ADDR_SZ-2:0], r_k[0]};
  assign w_last_q  = (r_q == r_o - 1'b1);
  assign w_last_r  = (r_r == r_o - 1'b1);
  assign w_last_c  = (r_c == r_c_num - 1'b1);

  pool_reduce_2x2 #(.DATA_SZ(DATA_SZ), .RELU(RELU)) u_reduce (
    .i_mode   (r_mode),
    .i_w0     (r_win[0]),
    .i_w1     (r_win[1]),
    .i_w2     (r_win[2]),
    .i_w3     (r_win[3]),
    .o_result (w_pooled)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // The q/r/c advance is folded into WR so a window costs RD+WAIT x4 plus one WR.
  always_comb begin
    w_next    = r_state;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_wr_data = '0;
    o_done    = 1'b0;
    case (r_state)
      S_IDLE:  if (i_enable) w_next = S_START;
      S_START: w_next = (r_c_num == '0 || r_s < DATA_SZ'(2)) ? S_DONE : S_RD;
      S_RD: begin
        o_rd_en   = 1'b1;
        o_rd_addr = w_rd_addr;
        w_next    = S_WAIT;
      end
      S_WAIT:  if (i_rd_valid) w_next = (r_k == 2'd3) ? S_WR : S_RD;
      S_WR: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_wr_addr;
        o_wr_data = w_pooled;
        w_next    = (w_last_q && w_last_r && w_last_c) ? S_DONE : S_RD;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode     <= POOL_AVG;
      r_c_num    <= '0;
      r_s        <= '0;
      r_o        <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_k        <= '0;
      r_ss       <= '0;
      r_map_base <= '0;
      r_row_base <= '0;
      r_wr_addr  <= '0;
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_enable) begin
          r_mode     <= i_mode;
          r_c_num    <= i_imgs_number;
          r_s        <= i_img_size;
          r_o        <= i_img_size >> 1;
          r_map_base <= i_in_address;
          r_row_base <= i_in_address;
          r_wr_addr  <= i_out_address;
          r_q        <= '0;
          r_r        <= '0;
          r_c        <= '0;
          r_k        <= '0;
        end
        S_START: r_ss <= w_s_a * w_s_a;
        S_WAIT: if (i_rd_valid) begin
          r_win[r_k] <= i_rd_data;
          r_k        <= r_k + 2'd1;
        end
        S_WR: begin
          r_wr_addr <= r_wr_addr + 1'b1;
          if (!w_last_q) begin
            r_q <= r_q + 1'b1;
          end else begin
            r_q <= '0;
            if (!w_last_r) begin
              r_r        <= r_r + 1'b1;
              r_row_base <= r_row_base + (w_s_a << 1);
            end else begin
              r_r        <= '0;
              r_c        <= r_c + 1'b1;
              r_map_base <= r_map_base + r_ss;
              r_row_base <= r_map_base + r_ss;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
